bp_l15_miss_engine: RTL and testbench

BP_L15_MISS_ENGINE -- requirements
Module: bp_l15_miss_engine

---
 rtl/bp_l15_miss_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_bp_l15_miss_engine.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_l15_miss_engine.sv
// L1.5 miss engine: cached line fills, uncached loads and stores over the transducer interface.
// Define BP_L15_MISS_ENGINE_INVAL_EN to forward EVICT_REQ returns on the inval port.
module bp_l15_miss_engine #(
   parameter int paddr_width_p = 40,
   parameter int beats_p       = 4,
   parameter int way_width_p   = 3
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   output logic                       ready_o,
   input  logic                       miss_v_i,
   output logic                       miss_yumi_o,
   input  logic                       uncached_i,
   input  logic                       store_i,
   input  logic [paddr_width_p-1:0]   miss_addr_i,
   input  logic [way_width_p-1:0]     way_i,
   input  logic [1:0]                 size_op_i,
   input  logic [63:0]                store_data_i,
   output logic [4:0]                 transducer_l15_rqtype,
   output logic                       transducer_l15_nc,
   output logic [2:0]                 transducer_l15_size,
   output logic                       transducer_l15_val,
   output logic [39:0]                transducer_l15_address,
   output logic [63:0]                transducer_l15_data,
   output logic [1:0]                 transducer_l15_l1rplway,
   input  logic                       l15_transducer_ack,
   input  logic                       l15_transducer_val,
   input  logic [3:0]                 l15_transducer_returntype,
   input  logic [63:0]                l15_transducer_data_0,
   input  logic [63:0]                l15_transducer_data_1,
   input  logic [11:0]                l15_transducer_inval_address_15_4,
   output logic                       transducer_l15_req_ack,
   output logic                       fill_v_o,
   input  logic                       fill_yumi_i,
   output logic [128*beats_p-1:0]     fill_data_o,
   output logic [paddr_width_p-1:0]   fill_addr_o,
   output logic [way_width_p-1:0]     fill_way_o,
   output logic                       fill_uncached_o,
   output logic                       inval_v_o,
   output logic [11:0]                inval_addr_o,
   input  logic                       inval_yumi_i
);

   localparam int LineOffW = 4 + $clog2(beats_p);
   localparam int LineW    = 128 * beats_p;
   localparam logic [4:0] LoadRq   = 5'b00000;
   localparam logic [4:0] StoreRq  = 5'b00001;
   localparam logic [3:0] LoadRet  = 4'h0;
   localparam logic [3:0] EvictReq = 4'h3;
   localparam logic [3:0] StAck    = 4'h4;
   localparam logic [3:0] IntRet   = 4'h7;
   localparam logic [2:0] Size16   = 3'd7;

   typedef enum logic [2:0] {StReset, StReady, StLdSend, StLdWait, StFill, StStSend, StStWait} state_e;

   state_e             state_q;
   logic [2:0]         cnt_q;
   logic [LineW-1:0]   line_q;
   logic               ready_q, fill_v_q, req_val_q, req_nc_q;
   logic [4:0]         req_rqtype_q;
   logic [2:0]         req_size_q;
   logic [39:0]        req_addr_q;
   logic [63:0]        req_data_q;
   logic [1:0]         req_way_q;

   logic [paddr_width_p-1:0] line_base;
   logic [39:0]        miss_addr40, line_base40;
   logic [2:0]         cnt_inc;
   logic [63:0]        st_data, uc_dword, uc_shift, uc_result;
   logic               ret_v, evict_capture, inval_done, ret_ack, ld_ret, st_ack;

   assign line_base   = {miss_addr_i[paddr_width_p-1:LineOffW], {LineOffW{1'b0}}};
   assign miss_addr40 = 40'(miss_addr_i);
   assign line_base40 = 40'(line_base);
   assign cnt_inc     = cnt_q + 3'd1;

`ifdef BP_L15_MISS_ENGINE_INVAL_EN
   logic        inval_v_q;
   logic [11:0] inval_addr_q;

   // A pending invalidation owns req_ack; the L1.5 holds further returns until it is acked.
   assign ret_v         = l15_transducer_val & ~inval_v_q;
   assign evict_capture = ret_v & (state_q != StReset) & (l15_transducer_returntype == EvictReq);
   assign inval_done    = inval_v_q & inval_yumi_i;
   assign inval_v_o     = inval_v_q;
   assign inval_addr_o  = inval_addr_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         inval_v_q    <= 1'b0;
         inval_addr_q <= '0;
      end else if (inval_done) begin
         inval_v_q    <= 1'b0;
         inval_addr_q <= '0;
      end else if (evict_capture) begin
         inval_v_q    <= 1'b1;
         inval_addr_q <= l15_transducer_inval_address_15_4;
      end
   end
`else
   logic unused_inval;
   assign unused_inval  = ^{inval_yumi_i, l15_transducer_inval_address_15_4};
   assign ret_v         = l15_transducer_val;
   assign evict_capture = 1'b0;
   assign inval_done    = 1'b0;
   assign inval_v_o     = 1'b0;
   assign inval_addr_o  = '0;
`endif

   assign ret_ack = ret_v & ((state_q == StReset) ? (l15_transducer_returntype == IntRet)
                                                  : ~evict_capture);
   assign ld_ret  = ret_v & (state_q == StLdWait) & (l15_transducer_returntype == LoadRet);
   assign st_ack  = ret_v & (state_q == StStWait) & (l15_transducer_returntype == StAck);

   assign transducer_l15_req_ack = ret_ack | inval_done;
   assign miss_yumi_o = ((state_q == StFill) & fill_yumi_i) | st_ack;

   always_comb begin
      case (size_op_i)
         2'd0:    st_data = {8{store_data_i[7:0]}};
         2'd1:    st_data = {4{store_data_i[15:0]}};
         2'd2:    st_data = {2{store_data_i[31:0]}};
         default: st_data = store_data_i;
      endcase
   end

   always_comb begin
      uc_dword = miss_addr_i[3] ? line_q[127:64] : line_q[63:0];
      uc_shift = uc_dword >> {miss_addr_i[2:0], 3'b000};
      case (size_op_i)
         2'd0:    uc_result = {56'd0, uc_shift[7:0]};
         2'd1:    uc_result = {48'd0, uc_shift[15:0]};
         2'd2:    uc_result = {32'd0, uc_shift[31:0]};
         default: uc_result = uc_shift;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StReset;
         cnt_q        <= '0;
         ready_q      <= 1'b0;
         fill_v_q     <= 1'b0;
         req_val_q    <= 1'b0;
         req_rqtype_q <= '0;
         req_nc_q     <= 1'b0;
         req_size_q   <= '0;
         req_addr_q   <= '0;
         req_data_q   <= '0;
         req_way_q    <= '0;
      end else begin
         // Request fields drop to zero once accepted; reloads below take precedence.
         if (req_val_q && l15_transducer_ack) begin
            req_val_q    <= 1'b0;
            req_rqtype_q <= '0;
            req_nc_q     <= 1'b0;
            req_size_q   <= '0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_way_q    <= '0;
         end
         case (state_q)
            StReset: if (ret_ack) begin
               state_q <= StReady;
               ready_q <= 1'b1;
            end
            StReady: if (miss_v_i) begin
               ready_q   <= 1'b0;
               req_val_q <= 1'b1;
               req_nc_q  <= uncached_i;
               req_way_q <= way_i[1:0];
               if (store_i) begin
                  state_q      <= StStSend;
                  req_rqtype_q <= StoreRq;
                  req_size_q   <= {1'b0, size_op_i};
                  req_addr_q   <= miss_addr40;
                  req_data_q   <= st_data;
               end else begin
                  state_q      <= StLdSend;
                  req_rqtype_q <= LoadRq;
                  req_size_q   <= uncached_i ? {1'b0, size_op_i} : Size16;
                  req_addr_q   <= uncached_i ? miss_addr40 : line_base40;
               end
            end
            StLdSend: if (l15_transducer_ack) state_q <= StLdWait;
            StLdWait: if (ld_ret) begin
               for (int b = 0; b < beats_p; b++) begin
                  if (cnt_q == 3'(b)) begin
                     line_q[b*128 +: 128] <= {l15_transducer_data_1, l15_transducer_data_0};
                  end
               end
               cnt_q <= cnt_inc;
               if (uncached_i || cnt_q == 3'(beats_p - 1)) begin
                  state_q  <= StFill;
                  fill_v_q <= 1'b1;
               end else begin
                  state_q      <= StLdSend;
                  req_val_q    <= 1'b1;
                  req_rqtype_q <= LoadRq;
                  req_nc_q     <= 1'b0;
                  req_size_q   <= Size16;
                  req_addr_q   <= line_base40 | 40'({cnt_inc, 4'b0000});
                  req_way_q    <= way_i[1:0];
               end
            end
            StFill: if (fill_yumi_i) begin
               state_q  <= StReady;
               fill_v_q <= 1'b0;
               ready_q  <= 1'b1;
               cnt_q    <= '0;
            end
            StStSend: if (l15_transducer_ack) state_q <= StStWait;
            StStWait: if (st_ack) begin
               state_q <= StReady;
               ready_q <= 1'b1;
            end
            default: state_q <= StReset;
         endcase
      end
   end

   assign ready_o                 = ready_q;
   assign fill_v_o                = fill_v_q;
   assign transducer_l15_val      = req_val_q;
   assign transducer_l15_rqtype   = req_rqtype_q;
   assign transducer_l15_nc       = req_nc_q;
   assign transducer_l15_size     = req_size_q;
   assign transducer_l15_address  = req_addr_q;
   assign transducer_l15_data     = req_data_q;
   assign transducer_l15_l1rplway = req_way_q;

   always_comb begin
      fill_data_o     = '0;
      fill_addr_o     = '0;
      fill_way_o      = '0;
      fill_uncached_o = 1'b0;
      if (fill_v_q) begin
         fill_addr_o     = line_base;
         fill_way_o      = way_i;
         fill_uncached_o = uncached_i;
         if (uncached_i) fill_data_o[63:0] = uc_result;
         else            fill_data_o       = line_q;
      end
   end

endmodule

// File: tb/tb_bp_l15_miss_engine.sv
// Directed bench for bp_l15_miss_engine: cached fill, uncached loads, store, fill stall,
// eviction handling (either build of BP_L15_MISS_ENGINE_INVAL_EN) and mid-transaction reset.
module tb_bp_l15_miss_engine;

   localparam logic [3:0] LoadRet  = 4'h0;
   localparam logic [3:0] EvictReq = 4'h3;
   localparam logic [3:0] StAck    = 4'h4;
   localparam logic [3:0] IntRet   = 4'h7;

   logic         clk = 1'b0;
   logic         reset_i;
   logic         ready_o, miss_v_i, miss_yumi_o, uncached_i, store_i;
   logic [39:0]  miss_addr_i;
   logic [2:0]   way_i;
   logic [1:0]   size_op_i;
   logic [63:0]  store_data_i;
   logic [4:0]   rqtype;
   logic         nc, req_val, l15_ack, l15_val, req_ack;
   logic [2:0]   size;
   logic [39:0]  address;
   logic [63:0]  data, ret_d0, ret_d1;
   logic [1:0]   rplway;
   logic [3:0]   rettype;
   logic [11:0]  ret_inval_addr;
   logic         fill_v_o, fill_yumi_i, fill_uncached_o, inval_v_o, inval_yumi_i;
   logic [511:0] fill_data_o;
   logic [39:0]  fill_addr_o;
   logic [2:0]   fill_way_o;
   logic [11:0]  inval_addr_o;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [2:0]   cur_way;
   logic [511:0] exp_line;
   logic [63:0]  lo, hi;

   always #5 clk = ~clk;

   bp_l15_miss_engine dut (
      .clk_i                             (clk),
      .reset_i                           (reset_i),
      .ready_o                           (ready_o),
      .miss_v_i                          (miss_v_i),
      .miss_yumi_o                       (miss_yumi_o),
      .uncached_i                        (uncached_i),
      .store_i                           (store_i),
      .miss_addr_i                       (miss_addr_i),
      .way_i                             (way_i),
      .size_op_i                         (size_op_i),
      .store_data_i                      (store_data_i),
      .transducer_l15_rqtype             (rqtype),
      .transducer_l15_nc                 (nc),
      .transducer_l15_size               (size),
      .transducer_l15_val                (req_val),
      .transducer_l15_address            (address),
      .transducer_l15_data               (data),
      .transducer_l15_l1rplway           (rplway),
      .l15_transducer_ack                (l15_ack),
      .l15_transducer_val                (l15_val),
      .l15_transducer_returntype         (rettype),
      .l15_transducer_data_0             (ret_d0),
      .l15_transducer_data_1             (ret_d1),
      .l15_transducer_inval_address_15_4 (ret_inval_addr),
      .transducer_l15_req_ack            (req_ack),
      .fill_v_o                          (fill_v_o),
      .fill_yumi_i                       (fill_yumi_i),
      .fill_data_o                       (fill_data_o),
      .fill_addr_o                       (fill_addr_o),
      .fill_way_o                        (fill_way_o),
      .fill_uncached_o                   (fill_uncached_o),
      .inval_v_o                         (inval_v_o),
      .inval_addr_o                      (inval_addr_o),
      .inval_yumi_i                      (inval_yumi_i)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_ret(input logic [3:0] t, input logic [63:0] a, input logic [63:0] b);
      l15_val = 1'b1;
      rettype = t;
      ret_d0  = a;
      ret_d1  = b;
   endtask

   task automatic start_miss(input logic st, input logic uc, input logic [39:0] addr,
                             input logic [2:0] way, input logic [1:0] sz, input logic [63:0] sd);
      @(negedge clk);
      l15_val = 1'b0;
      miss_v_i = 1'b1; store_i = st; uncached_i = uc; miss_addr_i = addr;
      way_i = way; size_op_i = sz; store_data_i = sd;
      cur_way = way;
      #1;
      chk("ready_idle", ready_o, 1);
      chk("yumi_idle", miss_yumi_o, 0);
   endtask

   // One load request/response: check the request, optionally stall the ack, return data.
   task automatic ld_beat(input logic [39:0] ea, input logic [2:0] es, input logic enc,
                          input int stall, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      l15_val = 1'b0;
      #1;
      chk("ld_val", req_val, 1);
      chk("ld_addr", address, ea);
      chk("ld_size", size, es);
      chk("ld_nc", nc, enc);
      chk("ld_rqtype", rqtype, 0);
      chk("ld_data_zero", data, 0);
      chk("ld_rplway", rplway, cur_way[1:0]);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         #1;
         chk("ld_hold_val", req_val, 1);
         chk("ld_hold_addr", address, ea);
      end
      l15_ack = 1'b1;
      @(negedge clk);
      l15_ack = 1'b0;
      send_ret(LoadRet, a, b);
      #1;
      chk("ld_req_ack", req_ack, 1);
      chk("ld_val_off", req_val, 0);
   endtask

   task automatic fill_accept(input logic [511:0] ed, input logic [39:0] ea, input logic euc,
                              input int extra);
      @(negedge clk);
      l15_val = 1'b0;
      #1;
      chk("fill_v", fill_v_o, 1);
      chk("fill_data", fill_data_o, ed);
      chk("fill_addr", fill_addr_o, ea);
      chk("fill_uc", fill_uncached_o, euc);
      chk("fill_way", fill_way_o, cur_way);
      chk("fill_no_yumi", miss_yumi_o, 0);
      for (int i = 0; i < extra; i++) begin
         @(negedge clk);
         #1;
         chk("fill_stall_v", fill_v_o, 1);
         chk("fill_stall_data", fill_data_o, ed);
         chk("fill_stall_yumi", miss_yumi_o, 0);
      end
      fill_yumi_i = 1'b1;
      #1;
      chk("fill_miss_yumi", miss_yumi_o, 1);
      @(negedge clk);
      fill_yumi_i = 1'b0;
      miss_v_i = 1'b0;
      #1;
      chk("fill_done_v", fill_v_o, 0);
      chk("fill_done_data", fill_data_o, 0);
      chk("fill_done_ready", ready_o, 1);
   endtask

   task automatic inject_evict();
      @(negedge clk);
      send_ret(EvictReq, 64'd0, 64'd0);
      ret_inval_addr = 12'hABC;
      #1;
`ifdef BP_L15_MISS_ENGINE_INVAL_EN
      chk("evict_no_ack", req_ack, 0);
      @(negedge clk);
      l15_val = 1'b0;
      #1;
      chk("inval_v", inval_v_o, 1);
      chk("inval_addr", inval_addr_o, 12'hABC);
      chk("inval_wait_ack", req_ack, 0);
      chk("inval_ld_val", req_val, 1);
      @(negedge clk);
      #1;
      chk("inval_hold", inval_v_o, 1);
      inval_yumi_i = 1'b1;
      #1;
      chk("inval_req_ack", req_ack, 1);
      @(negedge clk);
      inval_yumi_i = 1'b0;
      #1;
      chk("inval_clear", inval_v_o, 0);
`else
      chk("evict_ack", req_ack, 1);
      chk("evict_no_inval", inval_v_o, 0);
      @(negedge clk);
      l15_val = 1'b0;
      #1;
      chk("evict_no_inval2", inval_v_o, 0);
      chk("evict_ld_val", req_val, 1);
`endif
   endtask

   initial begin
      reset_i = 1'b1;
      miss_v_i = 1'b0; store_i = 1'b0; uncached_i = 1'b0; miss_addr_i = '0;
      way_i = '0; size_op_i = '0; store_data_i = '0; cur_way = '0;
      l15_ack = 1'b0; l15_val = 1'b0; rettype = '0; ret_d0 = '0; ret_d1 = '0;
      ret_inval_addr = '0; fill_yumi_i = 1'b0; inval_yumi_i = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", ready_o, 0);
      chk("rst_miss_yumi", miss_yumi_o, 0);
      chk("rst_val", req_val, 0);
      chk("rst_req_ack", req_ack, 0);
      chk("rst_fill_v", fill_v_o, 0);
      chk("rst_inval_v", inval_v_o, 0);

      // Non-INT_RET returns are ignored in RESET; the first INT_RET is acked.
      @(negedge clk);
      reset_i = 1'b0;
      send_ret(LoadRet, 64'h1, 64'h2);
      #1;
      chk("reset_ignore_ack", req_ack, 0);
      chk("reset_not_ready", ready_o, 0);
      @(negedge clk);
      send_ret(IntRet, 64'd0, 64'd0);
      #1;
      chk("int_ret_ack", req_ack, 1);
      @(negedge clk);
      l15_val = 1'b0;
      #1;
      chk("ready_after_int", ready_o, 1);

      // Cached 4-beat load, eviction between beats 1 and 2, 5-cycle fill stall.
      start_miss(1'b0, 1'b0, 40'h80001234, 3'b101, 2'b00, 64'd0);
      exp_line = '0;
      for (int b = 0; b < 4; b++) begin
         lo = {48'h1111_2222_3333, 16'(b)};
         hi = {48'h4444_5555_6666, 16'(b) + 16'h0100};
         exp_line[b*128 +: 128] = {hi, lo};
         if (b == 2) inject_evict();
         ld_beat(40'h80001200 + 40'(16 * b), 3'd7, 1'b0, (b == 0) ? 1 : 0, lo, hi);
      end
      fill_accept(exp_line, 40'h80001200, 1'b0, 4);

      // Uncached 2B load at offset 6 of the low dword.
      start_miss(1'b0, 1'b1, 40'h80000006, 3'b010, 2'b01, 64'd0);
      ld_beat(40'h80000006, 3'd1, 1'b1, 0, 64'h1122334455667788, 64'hDEADBEEFCAFEF00D);
      fill_accept(512'h1122, 40'h80000000, 1'b1, 0);

      // 1B store, with an unexpected return dropped while waiting for ST_ACK.
      start_miss(1'b1, 1'b0, 40'h80000003, 3'b011, 2'b00, 64'h123456789ABCDEAB);
      @(negedge clk);
      #1;
      chk("st_val", req_val, 1);
      chk("st_rqtype", rqtype, 1);
      chk("st_size", size, 0);
      chk("st_addr", address, 40'h80000003);
      chk("st_data", data, 64'hABABABABABABABAB);
      chk("st_rplway", rplway, 2'b11);
      l15_ack = 1'b1;
      @(negedge clk);
      l15_ack = 1'b0;
      send_ret(LoadRet, 64'd0, 64'd0);
      #1;
      chk("st_val_off", req_val, 0);
      chk("st_unexp_ack", req_ack, 1);
      chk("st_unexp_no_yumi", miss_yumi_o, 0);
      @(negedge clk);
      send_ret(StAck, 64'd0, 64'd0);
      #1;
      chk("st_ack_req_ack", req_ack, 1);
      chk("st_ack_miss_yumi", miss_yumi_o, 1);
      chk("st_no_fill", fill_v_o, 0);
      @(negedge clk);
      l15_val = 1'b0;
      miss_v_i = 1'b0;
      #1;
      chk("st_done_ready", ready_o, 1);
      chk("st_done_fill", fill_v_o, 0);

      // Reset during LD_WAIT of beat 2 abandons the load.
      start_miss(1'b0, 1'b0, 40'h00000047, 3'b001, 2'b00, 64'd0);
      ld_beat(40'h00000040, 3'd7, 1'b0, 0, 64'hA, 64'hB);
      ld_beat(40'h00000050, 3'd7, 1'b0, 0, 64'hC, 64'hD);
      @(negedge clk);
      l15_val = 1'b0;
      #1;
      chk("rst_mid_addr", address, 40'h00000060);
      l15_ack = 1'b1;
      @(negedge clk);
      l15_ack = 1'b0;
      reset_i = 1'b1;
      miss_v_i = 1'b0;
      @(negedge clk);
      reset_i = 1'b0;
      #1;
      chk("rst_mid_ready", ready_o, 0);
      chk("rst_mid_val", req_val, 0);
      chk("rst_mid_fill", fill_v_o, 0);
      chk("rst_mid_yumi", miss_yumi_o, 0);
      send_ret(LoadRet, 64'hE, 64'hF);
      #1;
      chk("rst_mid_ignore", req_ack, 0);
      @(negedge clk);
      #1;
      chk("rst_mid_no_fill", fill_v_o, 0);
      send_ret(IntRet, 64'd0, 64'd0);
      #1;
      chk("rst_mid_int_ack", req_ack, 1);
      @(negedge clk);
      l15_val = 1'b0;
      #1;
      chk("rst_mid_ready2", ready_o, 1);

      // Uncached 4B load from the high dword after recovery.
      start_miss(1'b0, 1'b1, 40'h8000000C, 3'b001, 2'b10, 64'd0);
      ld_beat(40'h8000000C, 3'd2, 1'b1, 0, 64'h1111111111111111, 64'hCAFEF00D12345678);
      fill_accept(512'hCAFEF00D, 40'h80000000, 1'b1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
